mc_ctrl: RTL and testbench
==========================

MC_CTRL -- requirements
Module: mc_ctrl

Interface
REQ-001 SHALL have ports: clk  in  1  sole clock, all state updates on rising edge.
REQ-002 SHALL have ports: reset  in  1  asynchronous, active-low (asserted at 0), one clock domain.
REQ-003 SHALL have ports: op  in  6  opcode field of the fetched instruction (insout[31:26]).
REQ-004 SHALL have ports: funct  in  6  function field (insout[5:0]).
REQ-005 SHALL have ports: zero  in  1  ALU equality flag.
REQ-006 SHALL have ports: pc_wr  out  1  PC update enable for the fetch unit.
REQ-007 SHALL have ports: ir_wr  out  1  instruction register load enable.
REQ-008 SHALL have ports: npc_sel, j_ctl  out  1 each  next-PC select, same meaning as the fetch unit inputs.
REQ-009 SHALL have ports: reg_wr  out  1; reg_dst  out  2 (00 rt, 01 rd); mem_to_reg  out  2 (00 ALU, 01 mem, 10 imm<<16).
REQ-010 SHALL have ports: alu_src  out  1 (1 = extended imm); alu_op  out  2 (00 add, 01 sub, 10 or); ext_op  out  1 (1 = sign, 0 = zero).
REQ-011 SHALL have ports: mem_wr  out  1; illegal  out  1 sticky undefined-instruction flag; state  out  4 debug.

Function
REQ-012 Supported instructions SHALL be addu (op 0, funct 0x21), subu (op 0, funct 0x23), ori 0x0D, lui 0x0F, lw 0x23, sw 0x2B, beq 0x04, j 0x02.
REQ-013 States SHALL be FETCH 0, DECODE 1, EXE 2, ALUWB 3, MEMADR 4, MEMRD 5, MEMWB 6, MEMWR 7, BRANCH 8, JUMP 9; encodings 10-15 are unreachable.
REQ-014 FETCH SHALL assert ir_wr=1 and pc_wr=1 with npc_sel=0 (PC+4), then go to DECODE.
REQ-015 DECODE SHALL go: R-type/ori/lui -> EXE; lw/sw -> MEMADR; beq -> BRANCH; j -> JUMP; else set illegal and go to FETCH.
REQ-016 An op 0 instruction with unsupported funct SHALL be treated as illegal in DECODE.
REQ-017 EXE SHALL drive alu_op by instruction: addu 00, subu 01, ori 10 with alu_src=1, ext_op=0; lui needs no ALU; then go to ALUWB.
REQ-018 ALUWB SHALL assert reg_wr=1 for one cycle: R-type reg_dst=01, mem_to_reg=00; ori reg_dst=00, mem_to_reg=00; lui reg_dst=00, mem_to_reg=10; then go to FETCH.
REQ-019 MEMADR SHALL drive alu_src=1, ext_op=1, alu_op=00; lw -> MEMRD, sw -> MEMWR.
REQ-020 MEMRD SHALL go to MEMWB; MEMWB SHALL assert reg_wr=1, reg_dst=00, mem_to_reg=01, then go to FETCH.
REQ-021 MEMWR SHALL assert mem_wr=1 for exactly one cycle, then go to FETCH.
REQ-022 BRANCH SHALL drive alu_op=01 and npc_sel=1, with pc_wr=zero; it SHALL then go to FETCH.
REQ-023 JUMP SHALL assert npc_sel=1, j_ctl=1, pc_wr=1, then go to FETCH.
REQ-024 Outputs SHALL be Moore-decoded from state and latched op/funct, except that BRANCH pc_wr follows the live zero input.
REQ-025 Every enable not named for a state SHALL be 0 in that state.
REQ-026 op/funct SHALL be captured into internal registers at the end of FETCH; later input changes SHALL NOT alter the instruction in flight.
REQ-027 Cycle counts SHALL be: R/ori/lui 4; lw 5; sw 4; beq 3; j 3; illegal 2.
REQ-028 An unreachable state encoding SHALL return to FETCH on the next edge.
REQ-029 illegal SHALL stay 1 until reset.

Reset
REQ-030 While reset=0, state SHALL be FETCH, latched op/funct SHALL be 0, and illegal SHALL be 0, all asynchronously.
REQ-031 On the first rising edge after reset deasserts, FETCH behaviour SHALL occur (pc_wr=1, ir_wr=1).
REQ-032 Reset asserted mid-instruction SHALL abort it immediately; no reg_wr or mem_wr pulse SHALL follow.

Structure
REQ-033 Opcode, funct, state encodings, and alu_op/mem_to_reg codes SHALL live in shared package mips_defs for reuse by the datapath.
REQ-034 The block SHALL use a single module with next-state and output decode in separate processes; no sub-module.

Verification
REQ-035 Test: reset low then high with op=0x23 (lw) -> state sequence 0,1,4,5,6,0; reg_wr=1 only in state 6 with mem_to_reg=01.
REQ-036 Test: beq with zero=1, then beq with zero=0 -> pc_wr=1 in BRANCH for the first and 0 for the second; both return to FETCH after 3 cycles.
REQ-037 Test: j (op 0x02) -> JUMP asserts npc_sel=1, j_ctl=1, pc_wr=1; total 3 cycles.
REQ-038 Test: op=0, funct=0x20 -> illegal=1 after DECODE, back in FETCH; a following addu completes normally with illegal still 1.
REQ-039 Test: sw, with reset pulled low during MEMADR -> state=0 asynchronously, mem_wr never asserted.
REQ-040 Test: change op during EXE of ori -> ALUWB still uses reg_dst=00, mem_to_reg=00.

Source files
------------

// File: rtl/mips_defs.sv
// Shared MIPS-subset definitions: opcodes, function codes, controller state
// encodings and the datapath select codes used by the controller and datapath.
package mips_defs;

  // Opcode field values (insout[31:26])
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ORI   = 6'h0D;
  localparam logic [5:0] OP_LUI   = 6'h0F;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // Function field values for op 0 (insout[5:0])
  localparam logic [5:0] FN_ADDU  = 6'h21;
  localparam logic [5:0] FN_SUBU  = 6'h23;

  // ALU operation select
  localparam logic [1:0] ALU_ADD  = 2'b00;
  localparam logic [1:0] ALU_SUB  = 2'b01;
  localparam logic [1:0] ALU_OR   = 2'b10;

  // Register-file write-data select
  localparam logic [1:0] M2R_ALU  = 2'b00;
  localparam logic [1:0] M2R_MEM  = 2'b01;
  localparam logic [1:0] M2R_LUI  = 2'b10;

  // Register-file destination select
  localparam logic [1:0] RDST_RT  = 2'b00;
  localparam logic [1:0] RDST_RD  = 2'b01;

  // Multi-cycle controller states; 10..15 are never entered
  typedef enum logic [3:0] {
    ST_FETCH  = 4'd0,
    ST_DECODE = 4'd1,
    ST_EXE    = 4'd2,
    ST_ALUWB  = 4'd3,
    ST_MEMADR = 4'd4,
    ST_MEMRD  = 4'd5,
    ST_MEMWB  = 4'd6,
    ST_MEMWR  = 4'd7,
    ST_BRANCH = 4'd8,
    ST_JUMP   = 4'd9
  } state_e;

  // Instruction class derived from op/funct
  typedef enum logic [3:0] {
    IC_ADDU = 4'd0,
    IC_SUBU = 4'd1,
    IC_ORI  = 4'd2,
    IC_LUI  = 4'd3,
    IC_LW   = 4'd4,
    IC_SW   = 4'd5,
    IC_BEQ  = 4'd6,
    IC_J    = 4'd7,
    IC_ILL  = 4'd8
  } instr_e;

  // Map an op/funct pair onto a supported instruction class
  function automatic instr_e classify(input logic [5:0] op_i, input logic [5:0] funct_i);
    instr_e ic;
    case (op_i)
      OP_RTYPE: begin
        if (funct_i == FN_ADDU) begin
          ic = IC_ADDU;
        end else if (funct_i == FN_SUBU) begin
          ic = IC_SUBU;
        end else begin
          ic = IC_ILL;
        end
      end
      OP_ORI:  ic = IC_ORI;
      OP_LUI:  ic = IC_LUI;
      OP_LW:   ic = IC_LW;
      OP_SW:   ic = IC_SW;
      OP_BEQ:  ic = IC_BEQ;
      OP_J:    ic = IC_J;
      default: ic = IC_ILL;
    endcase
    return ic;
  endfunction

endpackage

// File: rtl/mc_ctrl.sv
// Multi-cycle MIPS-subset main controller. Moore outputs decoded from the
// state register and the op/funct latched at the end of FETCH; only the
// BRANCH PC write follows the live ALU zero flag.
module mc_ctrl
  import mips_defs::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] op,
  input  logic [5:0] funct,
  input  logic       zero,
  output logic       pc_wr,
  output logic       ir_wr,
  output logic       npc_sel,
  output logic       j_ctl,
  output logic       reg_wr,
  output logic [1:0] reg_dst,
  output logic [1:0] mem_to_reg,
  output logic       alu_src,
  output logic [1:0] alu_op,
  output logic       ext_op,
  output logic       mem_wr,
  output logic       illegal,
  output logic [3:0] state
);

  state_e     state_q, state_d;
  logic [5:0] op_q, op_d;
  logic [5:0] funct_q, funct_d;
  logic       illegal_q, illegal_d;
  instr_e     ic;

  // The instruction in flight is always judged from the latched fields
  assign ic      = classify(op_q, funct_q);
  assign state   = state_q;
  assign illegal = illegal_q;

  // State, latched instruction fields and sticky illegal flag
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= ST_FETCH;
      op_q      <= 6'd0;
      funct_q   <= 6'd0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      funct_q   <= funct_d;
      illegal_q <= illegal_d;
    end
  end

  // Next-state sequencing, instruction capture and illegal detection
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    funct_d   = funct_q;
    illegal_d = illegal_q;
    case (state_q)
      ST_FETCH: begin
        op_d    = op;
        funct_d = funct;
        state_d = ST_DECODE;
      end
      ST_DECODE: begin
        case (ic)
          IC_ADDU, IC_SUBU, IC_ORI, IC_LUI: state_d = ST_EXE;
          IC_LW, IC_SW:                     state_d = ST_MEMADR;
          IC_BEQ:                           state_d = ST_BRANCH;
          IC_J:                             state_d = ST_JUMP;
          default: begin
            illegal_d = 1'b1;
            state_d   = ST_FETCH;
          end
        endcase
      end
      ST_EXE:    state_d = ST_ALUWB;
      ST_ALUWB:  state_d = ST_FETCH;
      ST_MEMADR: begin
        if (ic == IC_LW) begin
          state_d = ST_MEMRD;
        end else if (ic == IC_SW) begin
          state_d = ST_MEMWR;
        end else begin
          state_d = ST_FETCH;
        end
      end
      ST_MEMRD:  state_d = ST_MEMWB;
      ST_MEMWB:  state_d = ST_FETCH;
      ST_MEMWR:  state_d = ST_FETCH;
      ST_BRANCH: state_d = ST_FETCH;
      ST_JUMP:   state_d = ST_FETCH;
      default:   state_d = ST_FETCH;
    endcase
  end

  // Moore output decode; every enable is low unless the state names it
  always_comb begin
    pc_wr      = 1'b0;
    ir_wr      = 1'b0;
    npc_sel    = 1'b0;
    j_ctl      = 1'b0;
    reg_wr     = 1'b0;
    reg_dst    = RDST_RT;
    mem_to_reg = M2R_ALU;
    alu_src    = 1'b0;
    alu_op     = ALU_ADD;
    ext_op     = 1'b0;
    mem_wr     = 1'b0;
    case (state_q)
      ST_FETCH: begin
        ir_wr   = 1'b1;
        pc_wr   = 1'b1;
        npc_sel = 1'b0;
      end
      ST_EXE: begin
        case (ic)
          IC_ADDU: alu_op = ALU_ADD;
          IC_SUBU: alu_op = ALU_SUB;
          IC_ORI: begin
            alu_op  = ALU_OR;
            alu_src = 1'b1;
            ext_op  = 1'b0;
          end
          default: alu_op = ALU_ADD;
        endcase
      end
      ST_ALUWB: begin
        reg_wr = 1'b1;
        case (ic)
          IC_ADDU, IC_SUBU: begin
            reg_dst    = RDST_RD;
            mem_to_reg = M2R_ALU;
          end
          IC_LUI: begin
            reg_dst    = RDST_RT;
            mem_to_reg = M2R_LUI;
          end
          default: begin
            reg_dst    = RDST_RT;
            mem_to_reg = M2R_ALU;
          end
        endcase
      end
      ST_MEMADR: begin
        alu_src = 1'b1;
        ext_op  = 1'b1;
        alu_op  = ALU_ADD;
      end
      ST_MEMWB: begin
        reg_wr     = 1'b1;
        reg_dst    = RDST_RT;
        mem_to_reg = M2R_MEM;
      end
      ST_MEMWR: mem_wr = 1'b1;
      ST_BRANCH: begin
        alu_op  = ALU_SUB;
        npc_sel = 1'b1;
        pc_wr   = zero;
      end
      ST_JUMP: begin
        npc_sel = 1'b1;
        j_ctl   = 1'b1;
        pc_wr   = 1'b1;
      end
      default: pc_wr = 1'b0;
    endcase
  end

endmodule

// File: tb/tb_mc_ctrl.sv
// Self-checking bench for mc_ctrl: each instruction is expanded into the
// per-cycle control trace it should produce and compared against the DUT.
module tb_mc_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] op, funct;
  logic       zero;
  logic       pc_wr, ir_wr, npc_sel, j_ctl, reg_wr, alu_src, ext_op, mem_wr, illegal;
  logic [1:0] reg_dst, mem_to_reg, alu_op;
  logic [3:0] state;

  mc_ctrl dut (
    .clk(clk), .reset(reset), .op(op), .funct(funct), .zero(zero),
    .pc_wr(pc_wr), .ir_wr(ir_wr), .npc_sel(npc_sel), .j_ctl(j_ctl),
    .reg_wr(reg_wr), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
    .alu_src(alu_src), .alu_op(alu_op), .ext_op(ext_op), .mem_wr(mem_wr),
    .illegal(illegal), .state(state)
  );

  always #5 clk = ~clk;

  localparam int K_ADDU = 0, K_SUBU = 1, K_ORI = 2, K_LUI = 3, K_LW = 4,
                 K_SW = 5, K_BEQ = 6, K_J = 7, K_ILL = 8;

  int          n_vec = 0;
  int          n_err = 0;
  logic        ill_exp;
  logic [17:0] tr[$];
  logic        zs[0:7];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [17:0] obs();
    return {state, pc_wr, ir_wr, npc_sel, j_ctl, reg_wr, reg_dst, mem_to_reg,
            alu_src, alu_op, ext_op, mem_wr};
  endfunction

  // One expected cycle: state then every control output
  function automatic logic [17:0] rec(input logic [3:0] st, input logic pc, input logic ir,
                                      input logic npc, input logic j, input logic rw,
                                      input logic [1:0] rd, input logic [1:0] m2r,
                                      input logic asrc, input logic [1:0] ao,
                                      input logic eo, input logic mw);
    return {st, pc, ir, npc, j, rw, rd, m2r, asrc, ao, eo, mw};
  endfunction

  function automatic int kind_of(input logic [5:0] o, input logic [5:0] f);
    case (o)
      6'h00:   return (f == 6'h21) ? K_ADDU : (f == 6'h23) ? K_SUBU : K_ILL;
      6'h0D:   return K_ORI;
      6'h0F:   return K_LUI;
      6'h23:   return K_LW;
      6'h2B:   return K_SW;
      6'h04:   return K_BEQ;
      6'h02:   return K_J;
      default: return K_ILL;
    endcase
  endfunction

  // Expand an instruction class into its expected per-cycle trace
  task automatic build(input int k, input logic z2);
    tr.delete();
    tr.push_back(rec(4'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0));
    tr.push_back(rec(4'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0));
    case (k)
      K_ADDU, K_SUBU: begin
        tr.push_back(rec(4'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0,
                         (k == K_SUBU) ? 2'b01 : 2'b00, 1'b0, 1'b0));
        tr.push_back(rec(4'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b01, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0));
      end
      K_ORI: begin
        tr.push_back(rec(4'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b1, 2'b10, 1'b0, 1'b0));
        tr.push_back(rec(4'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0));
      end
      K_LUI: begin
        tr.push_back(rec(4'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0));
        tr.push_back(rec(4'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b10, 1'b0, 2'b00, 1'b0, 1'b0));
      end
      K_LW: begin
        tr.push_back(rec(4'd4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b1, 2'b00, 1'b1, 1'b0));
        tr.push_back(rec(4'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0));
        tr.push_back(rec(4'd6, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b00, 2'b01, 1'b0, 2'b00, 1'b0, 1'b0));
      end
      K_SW: begin
        tr.push_back(rec(4'd4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b1, 2'b00, 1'b1, 1'b0));
        tr.push_back(rec(4'd7, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 2'b00, 1'b0, 1'b1));
      end
      K_BEQ:
        tr.push_back(rec(4'd8, z2, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 2'b01, 1'b0, 1'b0));
      K_J:
        tr.push_back(rec(4'd9, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 2'b00, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0));
      default: ;
    endcase
  endtask

  // Run one instruction starting in FETCH. zmode: 0/1 fixed zero, 2 random.
  // scr scrambles op/funct after capture; abort_at pulls reset in that cycle.
  task automatic run_instr(input logic [5:0] o, input logic [5:0] f, input int zmode,
                           input bit scr, input int abort_at);
    int k;
    k = kind_of(o, f);
    for (int i = 0; i < 8; i++) zs[i] = (zmode == 2) ? 1'($urandom_range(0, 1)) : (zmode == 1);
    build(k, zs[2]);
    op = o;
    funct = f;
    for (int i = 0; i < tr.size(); i++) begin
      zero = zs[i];
      #1;
      chk($sformatf("op%h_f%h_cyc%0d", o, f, i), 32'(obs()), 32'(tr[i]));
      chk($sformatf("illegal_op%h_cyc%0d", o, i), 32'(illegal), 32'(ill_exp));
      if (i == abort_at) begin
        #1 reset = 1'b0;
        #1;
        chk("abort_state", 32'(state), 32'd0);
        chk("abort_illegal", 32'(illegal), 32'd0);
        chk("abort_mem_wr", 32'(mem_wr), 32'd0);
        repeat (2) begin
          @(posedge clk);
          #1;
          chk("rst_hold_state", 32'(state), 32'd0);
          chk("rst_hold_wr", 32'({mem_wr, reg_wr}), 32'd0);
        end
        @(negedge clk);
        reset = 1'b1;
        ill_exp = 1'b0;
        return;
      end
      if (scr && i >= 1) begin
        op = 6'($urandom);
        funct = 6'($urandom);
      end
      @(negedge clk);
    end
    if (k == K_ILL) ill_exp = 1'b1;
    #1;
    chk("ret_fetch", 32'(state), 32'd0);
  endtask

  initial begin
    logic [5:0] legal_op[0:7];
    logic [5:0] legal_fn[0:7];
    legal_op = '{6'h00, 6'h00, 6'h0D, 6'h0F, 6'h23, 6'h2B, 6'h04, 6'h02};
    legal_fn = '{6'h21, 6'h23, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00, 6'h00};
    reset = 1'b0;
    op = 6'h23;
    funct = 6'h00;
    zero = 1'b0;
    ill_exp = 1'b0;
    #2;
    chk("reset_outputs", 32'(obs()),
        32'(rec(4'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, 1'b0, 2'b00, 1'b0, 1'b0)));
    chk("reset_illegal", 32'(illegal), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b1;

    run_instr(6'h23, 6'h00, 0, 1'b0, -1);   // lw after reset
    run_instr(6'h04, 6'h00, 1, 1'b0, -1);   // beq taken
    run_instr(6'h04, 6'h00, 0, 1'b0, -1);   // beq not taken
    run_instr(6'h02, 6'h00, 2, 1'b0, -1);   // j
    run_instr(6'h00, 6'h20, 2, 1'b0, -1);   // add: unsupported funct
    run_instr(6'h00, 6'h21, 2, 1'b0, -1);   // addu with illegal sticky
    run_instr(6'h0D, 6'h00, 2, 1'b1, -1);   // ori with op changed in flight
    run_instr(6'h0F, 6'h00, 2, 1'b1, -1);   // lui
    run_instr(6'h00, 6'h23, 2, 1'b1, -1);   // subu
    run_instr(6'h2B, 6'h00, 2, 1'b0, 2);    // sw aborted in MEMADR
    run_instr(6'h2B, 6'h00, 2, 1'b0, -1);   // sw completes after reset

    for (int n = 0; n < 200; n++) begin
      int sel;
      sel = $urandom_range(0, 9);
      if (sel < 8) begin
        run_instr(legal_op[sel], legal_fn[sel], 2, 1'($urandom_range(0, 1)), -1);
      end else if (sel == 8) begin
        run_instr(6'($urandom), 6'($urandom), 2, 1'($urandom_range(0, 1)), -1);
      end else begin
        run_instr(6'h00, 6'($urandom), 2, 1'($urandom_range(0, 1)), -1);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
